// File: rtl/svc_rv_soc_run_ctrl_if.sv
// Host-side start/result channel of the SoC run controller.
// The sequencer drives the master side, the controller sits on the slave side.
interface svc_rv_soc_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] timeout_limit;
    logic             abort;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [CNT_W-1:0] done_cycles;
    logic             done_timeout;

    modport master (
        output start_valid,
        output timeout_limit,
        output abort,
        output done_ready,
        input  start_ready,
        input  busy,
        input  done_valid,
        input  done_cycles,
        input  done_timeout
    );

    modport slave (
        input  start_valid,
        input  timeout_limit,
        input  abort,
        input  done_ready,
        output start_ready,
        output busy,
        output done_valid,
        output done_cycles,
        output done_timeout
    );
endinterface

// File: rtl/svc_rv_soc_run_ctrl.sv
// Run controller: holds the SoC in reset, releases it, and times the run
// until ebreak or timeout, returning the cycle count on a valid/ready port.
module svc_rv_soc_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    svc_rv_soc_run_ctrl_if.slave ctl,
    output logic                 soc_rst_n,
    input  logic                 soc_ebreak
);

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] RST_INIT = 8'(RST_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       rst_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_cnt_inc;
    logic [CNT_W-1:0] limit;
    logic             hit;

    // Saturating increment keeps an unlimited run from wrapping to 0
    assign run_cnt_inc = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    assign hit         = (limit != '0) && (run_cnt_inc == limit);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ctl.start_valid) state_nxt = RESET;
            end
            RESET: begin
                if (ctl.abort)          state_nxt = IDLE;
                else if (rst_cnt == 8'd1) state_nxt = RUN;
            end
            RUN: begin
                if (ctl.abort)            state_nxt = IDLE;
                else if (soc_ebreak || hit) state_nxt = DONE;
            end
            DONE: begin
                if (ctl.done_ready) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ctl.start_ready  <= 1'b1;
            ctl.busy         <= 1'b0;
            ctl.done_valid   <= 1'b0;
            ctl.done_cycles  <= '0;
            ctl.done_timeout <= 1'b0;
            soc_rst_n        <= 1'b0;
            rst_cnt          <= '0;
            run_cnt          <= '0;
            limit            <= '0;
        end else begin
            state           <= state_nxt;
            ctl.start_ready <= (state_nxt == IDLE);
            ctl.busy        <= (state_nxt == RESET) || (state_nxt == RUN);
            ctl.done_valid  <= (state_nxt == DONE);
            soc_rst_n       <= (state_nxt == RUN);
            unique case (state)
                IDLE: begin
                    if (ctl.start_valid) begin
                        limit   <= ctl.timeout_limit;
                        rst_cnt <= RST_INIT;
                    end
                end
                RESET: begin
                    rst_cnt <= rst_cnt - 8'd1;
                    run_cnt <= '0;
                end
                RUN: begin
                    // Abort beats ebreak and timeout: no result is recorded
                    if (!ctl.abort) begin
                        if (soc_ebreak) begin
                            ctl.done_cycles  <= run_cnt_inc;
                            ctl.done_timeout <= 1'b0;
                        end else if (hit) begin
                            ctl.done_cycles  <= limit;
                            ctl.done_timeout <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt_inc;
                        end
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svc_rv_soc_run_ctrl.sv
// Scoreboard bench for the SoC run controller: expected results are queued
// at start and popped by a monitor on each done handshake.
module tb_svc_rv_soc_run_ctrl;

    localparam int RST = 4;

    typedef struct packed {
        logic [31:0] c;
        logic        t;
    } res_t;

    logic clk;
    logic rst;
    logic soc_rst_n;
    logic soc_ebreak;

    int   checks;
    int   failures;
    res_t exp_q[$];
    res_t e;

    svc_rv_soc_run_ctrl_if #(.CNT_W(32)) ifc ();

    svc_rv_soc_run_ctrl #(
        .RST_CYCLES(RST),
        .CNT_W     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl       (ifc),
        .soc_rst_n (soc_rst_n),
        .soc_ebreak(soc_ebreak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the head of the queue
    always @(negedge clk) begin
        if (!rst && ifc.done_valid && ifc.done_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got cycles %0d expected none",
                         ifc.done_cycles);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycles", ifc.done_cycles, e.c);
                chk("done_timeout", 32'(ifc.done_timeout), 32'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_soc_rst_n"}, 32'(soc_rst_n), 0);
        chk({tag, "_start_ready"}, 32'(ifc.start_ready), 1);
        chk({tag, "_busy"}, 32'(ifc.busy), 0);
        chk({tag, "_done_valid"}, 32'(ifc.done_valid), 0);
        chk({tag, "_done_cycles"}, ifc.done_cycles, 0);
        chk({tag, "_done_timeout"}, 32'(ifc.done_timeout), 0);
    endtask

    // One run: abt>0 pulses abort in that RUN cycle, bp holds done_ready low
    task automatic run(input int lim, input int ebk, input int abt,
                       input int exp_c, input bit exp_t, input bit bp);
        int lows;
        bit fin;
        @(negedge clk);
        chk("start_ready", 32'(ifc.start_ready), 1);
        ifc.timeout_limit = lim;
        ifc.start_valid   = 1'b1;
        ifc.done_ready    = !bp;
        if (abt == 0) exp_q.push_back('{c: exp_c, t: exp_t});
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        lows = 0;
        repeat (RST) begin
            if (!soc_rst_n) lows++;
            @(posedge clk);
            #1;
        end
        chk("rst_low_cycles", lows, RST);
        chk("run_soc_rst_n", 32'(soc_rst_n), 1);
        chk("run_busy", 32'(ifc.busy), 1);
        fin = 1'b0;
        for (int k = 1; k <= 300 && !fin; k++) begin
            soc_ebreak = (k == ebk);
            ifc.abort  = (k == abt);
            @(posedge clk);
            #1;
            soc_ebreak = 1'b0;
            ifc.abort  = 1'b0;
            if (k == abt || ifc.done_valid) fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL run_bound: got no done expected done");
        end
        if (abt != 0) begin
            chk("abort_done_valid", 32'(ifc.done_valid), 0);
            chk("abort_soc_rst_n", 32'(soc_rst_n), 0);
            chk("abort_busy", 32'(ifc.busy), 0);
            chk("abort_start_ready", 32'(ifc.start_ready), 1);
            return;
        end
        chk("done_soc_rst_n", 32'(soc_rst_n), 0);
        chk("done_busy", 32'(ifc.busy), 0);
        chk("done_start_ready", 32'(ifc.start_ready), 0);
        if (bp) begin
            repeat (5) begin
                ifc.start_valid = 1'b1;
                @(posedge clk);
                #1;
                chk("bp_done_valid", 32'(ifc.done_valid), 1);
                chk("bp_done_cycles", ifc.done_cycles, exp_c);
                chk("bp_done_timeout", 32'(ifc.done_timeout), 32'(exp_t));
                chk("bp_start_ready", 32'(ifc.start_ready), 0);
                chk("bp_busy", 32'(ifc.busy), 0);
            end
            ifc.start_valid = 1'b0;
            ifc.done_ready  = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_start_ready", 32'(ifc.start_ready), 1);
        chk("post_done_valid", 32'(ifc.done_valid), 0);
        chk("idle_done_cycles", ifc.done_cycles, exp_c);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        soc_ebreak        = 1'b0;
        ifc.start_valid   = 1'b0;
        ifc.timeout_limit = '0;
        ifc.abort         = 1'b0;
        ifc.done_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;

        run(0, 20, 0, 20, 1'b0, 1'b0);
        run(10, 0, 0, 10, 1'b1, 1'b0);
        run(10, 10, 0, 10, 1'b0, 1'b0);
        run(0, 1, 0, 1, 1'b0, 1'b0);
        run(1, 0, 0, 1, 1'b1, 1'b0);
        run(0, 7, 0, 7, 1'b0, 1'b1);
        run(0, 3, 3, 0, 1'b0, 1'b0);
        run(5, 0, 0, 5, 1'b1, 1'b0);

        // Abort during RESET
        @(negedge clk);
        ifc.timeout_limit = 1;
        ifc.start_valid   = 1'b1;
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        @(posedge clk);
        #1;
        ifc.abort = 1'b1;
        @(posedge clk);
        #1;
        ifc.abort = 1'b0;
        chk("rabort_busy", 32'(ifc.busy), 0);
        chk("rabort_soc_rst_n", 32'(soc_rst_n), 0);
        chk("rabort_start_ready", 32'(ifc.start_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("rabort_done_valid", 32'(ifc.done_valid), 0);

        // ebreak held through RESET, then rst mid-run
        @(negedge clk);
        ifc.timeout_limit = 0;
        ifc.start_valid   = 1'b1;
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        soc_ebreak      = 1'b1;
        repeat (RST) @(posedge clk);
        #1;
        soc_ebreak = 1'b0;
        chk("ebk_rst_soc_rst_n", 32'(soc_rst_n), 1);
        chk("ebk_rst_done_valid", 32'(ifc.done_valid), 0);
        chk("ebk_rst_busy", 32'(ifc.busy), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("midrst");

        run(0, 2, 0, 2, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
